// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit_pkg
//  Description : Shared constants and FSM state encoding for the program
//                counter unit.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_unit_pkg;

  // 13-bit PC addresses an 8K-word instruction space.
  localparam int              PC_W         = 13;
  localparam logic [PC_W-1:0] RESET_VECTOR = 13'h0000;

  // Sequencer states; FAULT is only left through reset.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    FAULT    = 2'd2
  } pc_state_e;

endpackage : pc_unit_pkg
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit_if
//  Description : Control-flow request bus between the pipeline/stack side
//                (master) and the program counter unit (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_unit_if #(
  parameter int PC_W = pc_unit_pkg::PC_W
);

  // Requests and return-address stack feedback
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] stack_out;
  logic            stack_overflow;

  // Fetch address and stack strobes
  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic            write_stack;
  logic            read_stack;
  logic [PC_W-1:0] push_pc;
  logic            fault;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           call, ret, stack_out, stack_overflow,
    input  pc, pc_valid, write_stack, read_stack, push_pc, fault
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           call, ret, stack_out, stack_overflow,
    output pc, pc_valid, write_stack, read_stack, push_pc, fault
  );

endinterface : pc_unit_if
`default_nettype wire

// File: rtl/pc_unit_next_pc_mux.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_mux
//  Description : Combinational next-PC priority select used while running:
//                ret > call > jump > branch_taken > sequential increment.
//  Revision    : 1.0  initial release
// ============================================================================
module next_pc_mux #(
  parameter int PC_W = pc_unit_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic            ret,
  input  logic            call,
  input  logic            jump,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] jump_target,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] next_pc,
  output logic [PC_W-1:0] pc_inc
);

  // Increment drops the carry so the last word wraps to address zero.
  assign pc_inc = pc + PC_W'(1);

  // Priority select; ret holds pc because the popped address arrives later.
  always_comb begin
    next_pc = pc_inc;
    if (ret) begin
      next_pc = pc;
    end else if (call || jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule : next_pc_mux
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Program counter register and RUN/RET_WAIT/FAULT sequencer
//                with return-address stack push/pop strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              PC_W         = pc_unit_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_VECTOR = pc_unit_pkg::RESET_VECTOR
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  pc_state_e       state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_q;
  logic [PC_W-1:0] mux_pc;
  logic [PC_W-1:0] pc_inc;
  logic            run_go;

  next_pc_mux #(.PC_W(PC_W)) u_next_pc_mux (
    .pc            (pc_q),
    .ret           (bus.ret),
    .call          (bus.call),
    .jump          (bus.jump),
    .branch_taken  (bus.branch_taken),
    .jump_target   (bus.jump_target),
    .branch_target (bus.branch_target),
    .next_pc       (mux_pc),
    .pc_inc        (pc_inc)
  );

  // A request is honoured only in RUN, not stalled, not resetting and with a
  // healthy stack; a pending overflow moves to FAULT instead of touching it.
  assign run_go = (state_q == RUN) && !bus.stall && !bus.stack_overflow && !reset;

  // ret wins over call, so the two strobes are mutually exclusive; leaving
  // RUN (or stalling) drops them, so one request yields a single pulse.
  assign bus.read_stack  = run_go && bus.ret;
  assign bus.write_stack = run_go && bus.call && !bus.ret;
  assign bus.push_pc     = pc_inc;

  assign bus.pc       = pc_q;
  assign bus.pc_valid = (state_q == RUN);
  assign bus.fault    = (state_q == FAULT);

  // Next state and next pc; stall freezes everything including RET_WAIT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (!bus.stall) begin
      case (state_q)
        RUN: begin
          if (bus.stack_overflow) begin
            state_d = FAULT;
          end else begin
            pc_d = mux_pc;
            if (bus.ret) begin
              state_d = RET_WAIT;
            end
          end
        end
        RET_WAIT: begin
          if (bus.stack_overflow) begin
            state_d = FAULT;
          end else begin
            pc_d    = bus.stack_out;
            state_d = RUN;
          end
        end
        default: begin
          state_d = FAULT;
        end
      endcase
    end
  end

  // State and pc registers; reset outranks stall and every request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Self-checking scoreboard bench for pc_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_unit;
  import pc_unit_pkg::*;

  localparam int W    = 13;
  localparam int MASK = 32'h1FFF;

  logic clk = 1'b0;
  logic reset;

  pc_unit_if #(.PC_W(W)) bus ();

  pc_unit #(.PC_W(W), .RESET_VECTOR(13'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] pc;
    logic         pv;
    logic         flt;
    logic         rs;
    logic         ws;
    logic [W-1:0] pp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_pc;
  int   m_st;   // 0 run, 1 ret-wait, 2 fault

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    reset              = 1'b0;
    bus.stall          = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.branch_target  = '0;
    bus.jump           = 1'b0;
    bus.jump_target    = '0;
    bus.call           = 1'b0;
    bus.ret            = 1'b0;
    bus.stack_out      = '0;
    bus.stack_overflow = 1'b0;
  endtask

  // Push this cycle's expected outputs, advance the reference model, clock.
  task automatic tick();
    exp_t e;
    logic go;
    go    = (m_st == 0) && !bus.stall && !bus.stack_overflow && !reset;
    e.pc  = W'(m_pc);
    e.pv  = (m_st == 0);
    e.flt = (m_st == 2);
    e.rs  = go && bus.ret;
    e.ws  = go && bus.call && !bus.ret;
    e.pp  = W'((m_pc + 1) & MASK);
    sb.push_back(e);
    if (reset) begin
      m_pc = 0;
      m_st = 0;
    end else if (!bus.stall) begin
      if (m_st == 0) begin
        if (bus.stack_overflow)  m_st = 2;
        else if (bus.ret)        m_st = 1;
        else if (bus.call)       m_pc = int'(bus.jump_target);
        else if (bus.jump)       m_pc = int'(bus.jump_target);
        else if (bus.branch_taken) m_pc = int'(bus.branch_target);
        else                     m_pc = (m_pc + 1) & MASK;
      end else if (m_st == 1) begin
        if (bus.stack_overflow) m_st = 2;
        else begin
          m_pc = int'(bus.stack_out);
          m_st = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check_val("pc",          32'(bus.pc),          32'(mon_e.pc));
      check_val("pc_valid",    32'(bus.pc_valid),    32'(mon_e.pv));
      check_val("fault",       32'(bus.fault),       32'(mon_e.flt));
      check_val("read_stack",  32'(bus.read_stack),  32'(mon_e.rs));
      check_val("write_stack", 32'(bus.write_stack), 32'(mon_e.ws));
      check_val("push_pc",     32'(bus.push_pc),     32'(mon_e.pp));
    end
  end

  initial begin
    idle_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_pc = 0;
    m_st = 0;
    tick();                                   // reset still high, state checked
    reset = 1'b0;

    // Sequential fetch after reset
    repeat (4) tick();
    check_val("seq_pc4", 32'(bus.pc), 32'h4);

    // Jump to 0x0010, then call 0x0200
    bus.jump = 1'b1; bus.jump_target = 13'h0010;
    tick(); idle_in();
    check_val("jump_dest", 32'(bus.pc), 32'h0010);
    bus.call = 1'b1; bus.jump_target = 13'h0200;
    #1;
    check_val("call_ws", 32'(bus.write_stack), 32'h1);
    check_val("call_push", 32'(bus.push_pc), 32'h0011);
    tick(); idle_in();
    check_val("call_dest", 32'(bus.pc), 32'h0200);

    // Return from 0x0205 to 0x0011
    repeat (5) tick();
    check_val("pre_ret_pc", 32'(bus.pc), 32'h0205);
    bus.ret = 1'b1;
    tick(); idle_in();
    bus.stack_out = 13'h0011;
    check_val("ret_wait_pv", 32'(bus.pc_valid), 32'h0);
    tick(); idle_in();
    check_val("ret_dest", 32'(bus.pc), 32'h0011);

    // Wrap at top of address space
    bus.branch_taken = 1'b1; bus.branch_target = 13'h1FFE;
    tick(); idle_in();
    tick();
    check_val("pc_top", 32'(bus.pc), 32'h1FFF);
    tick();
    check_val("pc_wrap", 32'(bus.pc), 32'h0000);

    // jump outranks branch
    bus.jump = 1'b1; bus.jump_target = 13'h0100;
    bus.branch_taken = 1'b1; bus.branch_target = 13'h0300;
    tick(); idle_in();

    // ret + call + branch together: only the pop strobe
    bus.ret = 1'b1; bus.call = 1'b1; bus.branch_taken = 1'b1;
    bus.jump_target = 13'h0777; bus.branch_target = 13'h0555;
    #1;
    check_val("combo_rs", 32'(bus.read_stack), 32'h1);
    check_val("combo_ws", 32'(bus.write_stack), 32'h0);
    tick(); idle_in();
    bus.stack_out = 13'h0ABC;
    tick(); idle_in();

    // Stall in RUN suppresses a call
    bus.stall = 1'b1; bus.call = 1'b1; bus.jump_target = 13'h0050;
    tick(); idle_in();

    // Stall held 3 cycles inside RET_WAIT
    bus.ret = 1'b1;
    tick(); idle_in();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.stack_out = W'($urandom);
      tick();
    end
    idle_in();
    bus.stack_out = 13'h0123;
    tick(); idle_in();
    check_val("stall_ret_dest", 32'(bus.pc), 32'h0123);

    // Reset during RET_WAIT abandons the return
    bus.ret = 1'b1;
    tick(); idle_in();
    reset = 1'b1; bus.stack_out = 13'h0999;
    tick(); idle_in();
    tick();

    // Underflow during return -> FAULT, held until reset
    bus.ret = 1'b1;
    tick(); idle_in();
    bus.stack_overflow = 1'b1; bus.stack_out = 13'h0AAA;
    tick();
    check_val("fault_set", 32'(bus.fault), 32'h1);
    bus.call = 1'b1; bus.jump = 1'b1; bus.jump_target = 13'h0444;
    tick();
    bus.call = 1'b0; bus.jump = 1'b0; bus.ret = 1'b1;
    tick(); idle_in();
    bus.stack_overflow = 1'b1;
    tick(); idle_in();
    reset = 1'b1;
    tick(); idle_in();
    check_val("fault_clr_pc", 32'(bus.pc), 32'h0000);
    check_val("fault_clr", 32'(bus.fault), 32'h0);
    tick();

    // Random mix of requests and stalls
    for (int i = 0; i < 60; i++) begin
      idle_in();
      bus.stall         = ($urandom_range(0, 4) == 0);
      bus.branch_taken  = ($urandom_range(0, 3) == 0);
      bus.branch_target = W'($urandom);
      bus.jump          = ($urandom_range(0, 5) == 0);
      bus.call          = ($urandom_range(0, 6) == 0);
      bus.ret           = ($urandom_range(0, 7) == 0);
      bus.jump_target   = W'($urandom);
      bus.stack_out     = W'($urandom);
      tick();
    end
    idle_in();
    tick();

    check_val("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pc_unit
`default_nettype wire

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_W, default 13, program-counter width in bits (8K-word instruction space).
REQ-002 Parameter RESET_VECTOR, default 13'h0000, PC value loaded on reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  high: hold PC, FSM state and all stack strobes low.
REQ-006 branch_taken  input  1  conditional branch resolved taken this cycle.
REQ-007 branch_target  input  PC_W  branch destination.
REQ-008 jump  input  1  unconditional jump request.
REQ-009 jump_target  input  PC_W  jump destination.
REQ-010 call  input  1  subroutine call request; destination is jump_target.
REQ-011 ret  input  1  subroutine return request.
REQ-012 stack_out  input  PC_W  return address from the return-address stack, valid the cycle after read_stack.
REQ-013 stack_overflow  input  1  sticky over/underflow flag from the stack.
REQ-014 pc  output  PC_W  current fetch address (registered).
REQ-015 pc_valid  output  1  high when pc is a fetchable address.
REQ-016 write_stack  output  1  one-cycle push strobe to the stack.
REQ-017 read_stack  output  1  one-cycle pop strobe to the stack.
REQ-018 push_pc  output  PC_W  return address to push, equal to pc+1 mod 2^PC_W.
REQ-019 fault  output  1  high in FAULT state.

Function
REQ-020 The FSM SHALL have exactly three states: RUN, RET_WAIT and FAULT.
REQ-021 In RUN without stall, next pc priority SHALL be: ret > call > jump > branch_taken > pc+1.
REQ-022 Sequential increment SHALL wrap: pc 8191 -> 0; no carry out.
REQ-023 On call in RUN: write_stack=1 and push_pc=pc+1 combinationally that cycle; pc<=jump_target next edge.
REQ-024 On ret in RUN: read_stack=1 that cycle; pc held; next state RET_WAIT.
REQ-025 In RET_WAIT: pc_valid=0; pc<=stack_out at the edge ending RET_WAIT; next state RUN; all request inputs ignored.
REQ-026 RET latency SHALL be 2 cycles from ret sampled to the popped address on pc.
REQ-027 stall SHALL freeze RET_WAIT as well (state and pc held, stack_out re-sampled on release).
REQ-028 stack_overflow sampled high in RUN or RET_WAIT SHALL move the FSM to FAULT at the next edge, overriding any pc update.
REQ-029 In FAULT: pc held, pc_valid=0, fault=1, read_stack=write_stack=0; exit only by reset.
REQ-030 read_stack and write_stack SHALL never be high in the same cycle, and never for two consecutive cycles from one request.
REQ-031 pc_valid SHALL be 1 in RUN, 0 otherwise.

Reset
REQ-032 reset SHALL take priority over stall and all requests.
REQ-033 Reset values: pc=RESET_VECTOR, state=RUN, pc_valid=1 after reset deasserts, fault=0, read_stack=0, write_stack=0.
REQ-034 Reset asserted in RET_WAIT SHALL abandon the return; the stack is reset by the same signal.

Structure
REQ-035 A shared package SHALL hold PC_W, RESET_VECTOR and the FSM state encoding (2-bit, RUN=0, RET_WAIT=1, FAULT=2).
REQ-036 The next-PC priority select SHALL be a sub-module next_pc_mux (combinational); the FSM and pc register stay in pc_unit.
REQ-037 Stack strobes SHALL be decoded combinationally from registered state and inputs; pc SHALL be a flop.

Verification
REQ-038 Reset, then 4 idle cycles -> pc = 0,1,2,3,4; pc_valid=1; strobes 0.
REQ-039 pc=0x0010, call with jump_target=0x0200 -> write_stack=1, push_pc=0x0011 that cycle; pc=0x0200 next cycle.
REQ-040 At pc=0x0205 ret, stack_out=0x0011 next cycle -> read_stack 1 cycle, pc_valid 0 for 1 cycle, pc=0x0011 two cycles after ret.
REQ-041 pc=0x1FFF no request -> pc=0x0000 next cycle; ret+call+branch_taken together -> only read_stack asserted.
REQ-042 ret with stack empty, stack_overflow rises next cycle -> FAULT, fault=1, pc frozen; reset -> pc=0, fault=0.
REQ-043 stall held 3 cycles during RET_WAIT -> pc and state unchanged, no extra read_stack; pc=stack_out one cycle after release.
